// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns one MEM-stage load/store at a time
// into word-aligned memory accesses with byte strobes. Boundary-crossing
// accesses are split in two, and a single-cycle response pulse is returned.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | access to the word holding the first byte
// ACC1  | access to the following word (boundary-crossing access only)
// RESP  | response pulse on rsp_vld_o
module dmem_access_ctrl #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld_i,
    output logic                  req_rdy_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [AWIDTH-1:0]     req_addr_i,
    input  logic [DWIDTH-1:0]     req_wdata_i,
    output logic                  rsp_vld_o,
    output logic [DWIDTH-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [AWIDTH-1:0]     mem_addr_o,
    output logic [DWIDTH-1:0]     mem_data_o,
    output logic [DWIDTH/8-1:0]   mem_write_strb_o,
    output logic                  mem_read_en_o,
    output logic                  mem_write_en_o,
    input  logic [DWIDTH-1:0]     mem_data_i,
    input  logic                  mem_data_vld_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [AWIDTH-1:0]     addr_q;
    logic [DWIDTH-1:0]     wdata_q;
    logic                  span_q;
    logic [2*DWIDTH-1:0]   buf_q, buf_d;
    logic                  rd_err_q, rd_err_d, rd_err_next;
    logic [DWIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [2:0]            in_n;
    logic                  in_legal, in_span, in_err;
    logic                  accept;

    logic [2:0]            n_q;
    logic [1:0]            off_q;
    logic [AWIDTH-1:0]     word_addr;
    logic [7:0]            strb_mask, strb8;
    logic [2*DWIDTH-1:0]   data64;
    logic                  rd_cycle;
    logic [2*DWIDTH-1:0]   shifted;
    logic [DWIDTH-1:0]     ext;
    logic                  sgn;

    function automatic logic [2:0] width_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign req_rdy_o = (state_q == IDLE);
    assign rsp_vld_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign accept    = req_vld_i && (state_q == IDLE);

    // Decode the incoming request: width, legality and word-boundary crossing
    always_comb begin
        in_n = width_bytes(req_funct3_i[1:0]);
        if (req_we_i) begin
            in_legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            in_legal = (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        in_span = (({1'b0, req_addr_i[1:0]} + in_n) > 3'd4);
        in_err  = !in_legal || (in_span && (SPLIT_EN == 0));
    end

    // Memory-side drive from state and the registered request only
    always_comb begin
        n_q       = width_bytes(f3_q[1:0]);
        off_q     = addr_q[1:0];
        word_addr = {addr_q[AWIDTH-1:2], 2'b00};
        case (n_q)
            3'd1:    strb_mask = 8'h01;
            3'd2:    strb_mask = 8'h03;
            default: strb_mask = 8'h0F;
        endcase
        strb8  = strb_mask << off_q;
        data64 = {{DWIDTH{1'b0}}, wdata_q} << {off_q, 3'b000};

        mem_addr_o       = '0;
        mem_data_o       = '0;
        mem_write_strb_o = '0;
        mem_read_en_o    = 1'b0;
        mem_write_en_o   = 1'b0;
        case (state_q)
            ACC0: begin
                mem_addr_o     = word_addr;
                mem_read_en_o  = !we_q && !rst;
                mem_write_en_o = we_q && !rst;
                if (we_q) begin
                    mem_write_strb_o = strb8[3:0];
                    mem_data_o       = data64[DWIDTH-1:0];
                end
            end
            ACC1: begin
                mem_addr_o     = word_addr + AWIDTH'(4);
                mem_read_en_o  = !we_q && !rst;
                mem_write_en_o = we_q && !rst;
                if (we_q) begin
                    mem_write_strb_o = strb8[7:4];
                    mem_data_o       = data64[2*DWIDTH-1:DWIDTH];
                end
            end
            default: ;
        endcase
    end

    // Load capture, read-valid tracking and result extension; the result
    // includes the word arriving in the current access cycle
    always_comb begin
        rd_cycle = ((state_q == ACC0) || (state_q == ACC1)) && !we_q;
        buf_d    = buf_q;
        if (rd_cycle && (state_q == ACC0)) buf_d[DWIDTH-1:0] = mem_data_i;
        if (rd_cycle && (state_q == ACC1)) buf_d[2*DWIDTH-1:DWIDTH] = mem_data_i;
        rd_err_d    = rd_err_q || (rd_cycle && !mem_data_vld_i);
        rd_err_next = accept ? 1'b0 : rd_err_d;

        shifted = buf_d >> {off_q, 3'b000};
        sgn     = !f3_q[2];
        case (n_q)
            3'd1:    ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
            3'd2:    ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: ext = shifted[DWIDTH-1:0];
        endcase
    end

    // Next state and response registers
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_vld_i) begin
                    if (in_err) begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ACC0;
                    end
                end
            end
            ACC0: begin
                if (span_q) begin
                    state_d = ACC1;
                end else begin
                    state_d     = RESP;
                    rsp_err_d   = rd_err_d;
                    rsp_rdata_d = (we_q || rd_err_d) ? '0 : ext;
                end
            end
            ACC1: begin
                state_d     = RESP;
                rsp_err_d   = rd_err_d;
                rsp_rdata_d = (we_q || rd_err_d) ? '0 : ext;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            span_q      <= 1'b0;
            buf_q       <= '0;
            rd_err_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            rd_err_q    <= rd_err_next;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                span_q  <= in_span;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a 16-word memory model, a response scoreboard
// and a log of memory-side access cycles.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_vld = 1'b0, req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        req_rdy, rsp_vld, rsp_err, mem_re, mem_we, mem_rvld;
    logic [31:0] rsp_rdata, mem_addr, mem_data, mem_rdata;
    logic [3:0]  mem_strb;

    logic        ns_req_rdy, ns_rsp_vld, ns_rsp_err, ns_mem_re, ns_mem_we;
    logic [31:0] ns_rsp_rdata, ns_mem_addr, ns_mem_data;
    logic [3:0]  ns_mem_strb;

    logic [31:0] mem_arr [16];
    logic        vld_ok = 1'b1;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'h0;

    assign mem_rdata = mem_arr[mem_addr[5:2]];
    assign mem_rvld  = vld_ok;

    dmem_access_ctrl #(.AWIDTH(32), .DWIDTH(32), .SPLIT_EN(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_vld_o(rsp_vld), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_write_strb_o(mem_strb),
        .mem_read_en_o(mem_re), .mem_write_en_o(mem_we),
        .mem_data_i(mem_rdata), .mem_data_vld_i(mem_rvld)
    );

    dmem_access_ctrl #(.AWIDTH(32), .DWIDTH(32), .SPLIT_EN(0)) u_dut_ns (
        .clk(clk), .rst(rst),
        .req_vld_i(req_vld), .req_rdy_o(ns_req_rdy), .req_we_i(req_we),
        .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_vld_o(ns_rsp_vld), .rsp_rdata_o(ns_rsp_rdata), .rsp_err_o(ns_rsp_err),
        .mem_addr_o(ns_mem_addr), .mem_data_o(ns_mem_data), .mem_write_strb_o(ns_mem_strb),
        .mem_read_en_o(ns_mem_re), .mem_write_en_o(ns_mem_we),
        .mem_data_i(32'h0), .mem_data_vld_i(1'b1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        re;
        logic        we;
    } acc_t;

    exp_t sb[$];
    acc_t acc_q[$];
    int   cyc = 0;
    int   ns_act_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: byte-strobed writes and preload port
    always @(posedge clk) begin
        if (pl_en) mem_arr[pl_idx] <= pl_val;
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) mem_arr[mem_addr[5:2]][8*b +: 8] <= mem_data[8*b +: 8];
            end
        end
    end

    // Monitor: access log, SPLIT_EN=0 activity and response scoreboard
    always @(negedge clk) begin
        if (mem_re || mem_we) acc_q.push_back('{cyc, mem_addr, mem_data, mem_strb, mem_re, mem_we});
        if (|{ns_mem_addr, ns_mem_data, ns_mem_strb, ns_mem_re, ns_mem_we}) ns_act_cnt <= ns_act_cnt + 1;
        if (rsp_vld) begin
            if (sb.size() == 0) begin
                chk_eq("unexpected_rsp", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk_eq("rsp_err", 64'(rsp_err), 64'(e.err));
                chk_eq("rsp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit push, output int t);
        @(negedge clk);
        chk_eq("req_rdy", 64'(req_rdy), 64'd1);
        req_vld = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
        t = cyc;
        if (push) sb.push_back('{exp_rdata, exp_err, cyc + lat});
        @(posedge clk);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_done();
        repeat (6) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            chk_eq("rsp_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic chk_acc(input string tag, input int base, input int i, input int t, input int dcyc,
                           input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                           input logic re, input logic we);
        logic [31:0] mask;
        acc_t a;
        if (acc_q.size() <= base + i) begin
            chk_eq({tag, "_count"}, 64'(acc_q.size()), 64'(base + i + 1));
        end else begin
            a = acc_q[base + i];
            chk_eq({tag, "_cycle"}, 64'(a.cyc), 64'(t + dcyc));
            chk_eq({tag, "_addr"}, 64'(a.addr), 64'(addr));
            chk_eq({tag, "_re"}, 64'(a.re), 64'(re));
            chk_eq({tag, "_we"}, 64'(a.we), 64'(we));
            if (we) begin
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
                chk_eq({tag, "_strb"}, 64'(a.strb), 64'(strb));
                chk_eq({tag, "_data"}, 64'(a.data & mask), 64'(data & mask));
            end
        end
    endtask

    initial begin
        int t, base, nsb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_eq("rst_req_rdy", 64'(req_rdy), 64'd1);
        chk_eq("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk_eq("rst_mem_en", 64'({mem_re, mem_we}), 64'd0);
        chk_eq("rst_mem_bus", 64'({mem_addr, mem_strb} ^ 36'h0), 64'd0);
        chk_eq("rst_mem_data", 64'(mem_data), 64'd0);

        // Aligned LW
        preload(4'd4, 32'h8899AABB);
        base = acc_q.size();
        issue(1'b0, 3'b010, 32'h01000010, 32'h0, 2, 32'h8899AABB, 1'b0, 1, t);
        wait_done();
        chk_eq("lw_acc_count", 64'(acc_q.size() - base), 64'd1);
        chk_acc("lw_acc", base, 0, t, 1, 32'h01000010, 4'h0, 32'h0, 1'b1, 1'b0);
        chk_eq("rsp_hold", 64'(rsp_rdata), 64'h8899AABB);

        // Sub-word loads with sign and zero extension
        preload(4'd4, 32'h80112233);
        issue(1'b0, 3'b000, 32'h01000013, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1, t); wait_done();
        issue(1'b0, 3'b100, 32'h01000013, 32'h0, 2, 32'h00000080, 1'b0, 1, t); wait_done();
        issue(1'b0, 3'b001, 32'h01000012, 32'h0, 2, 32'hFFFF8011, 1'b0, 1, t); wait_done();
        issue(1'b0, 3'b101, 32'h01000012, 32'h0, 2, 32'h00008011, 1'b0, 1, t); wait_done();
        issue(1'b0, 3'b000, 32'h01000010, 32'h0, 2, 32'h00000033, 1'b0, 1, t); wait_done();
        issue(1'b0, 3'b001, 32'h01000010, 32'h0, 2, 32'h00002233, 1'b0, 1, t); wait_done();

        // Split SH across the word boundary
        preload(4'd0, 32'h11111111);
        preload(4'd1, 32'h22222222);
        base = acc_q.size();
        issue(1'b1, 3'b001, 32'h01000003, 32'h0000BEEF, 3, 32'h0, 1'b0, 1, t);
        wait_done();
        chk_eq("sh_acc_count", 64'(acc_q.size() - base), 64'd2);
        chk_acc("sh_acc0", base, 0, t, 1, 32'h01000000, 4'b1000, 32'hEF000000, 1'b0, 1'b1);
        chk_acc("sh_acc1", base, 1, t, 2, 32'h01000004, 4'b0001, 32'h000000BE, 1'b0, 1'b1);
        chk_eq("sh_mem_lo", 64'(mem_arr[0]), 64'hEF111111);
        chk_eq("sh_mem_hi", 64'(mem_arr[1]), 64'h222222BE);

        // Split LW
        preload(4'd0, 32'h44332211);
        preload(4'd1, 32'h88776655);
        base = acc_q.size();
        issue(1'b0, 3'b010, 32'h01000002, 32'h0, 3, 32'h66554433, 1'b0, 1, t);
        wait_done();
        chk_acc("lw_split_acc1", base, 1, t, 2, 32'h01000004, 4'h0, 32'h0, 1'b1, 1'b0);

        // Aligned SW and a single-byte store into the same word
        base = acc_q.size();
        issue(1'b1, 3'b010, 32'h01000008, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, t);
        wait_done();
        chk_acc("sw_acc", base, 0, t, 1, 32'h01000008, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        base = acc_q.size();
        issue(1'b1, 3'b000, 32'h01000009, 32'h000000AA, 2, 32'h0, 1'b0, 1, t);
        wait_done();
        chk_acc("sb_acc", base, 0, t, 1, 32'h01000008, 4'b0010, 32'h0000AA00, 1'b0, 1'b1);
        chk_eq("sb_mem", 64'(mem_arr[2]), 64'hDEADAAEF);

        // Illegal funct3 for a load and for a store
        base = acc_q.size();
        issue(1'b0, 3'b011, 32'h01000010, 32'h0, 1, 32'h0, 1'b1, 1, t);
        wait_done();
        issue(1'b1, 3'b100, 32'h01000010, 32'h12345678, 1, 32'h0, 1'b1, 1, t);
        wait_done();
        chk_eq("err_no_access", 64'(acc_q.size() - base), 64'd0);
        chk_eq("err_mem_unchanged", 64'(mem_arr[4]), 64'h80112233);

        // Crossing LW: split in one instance, error in the non-splitting one
        nsb  = ns_act_cnt;
        base = acc_q.size();
        issue(1'b0, 3'b010, 32'h01000001, 32'h0, 3, 32'h55443322, 1'b0, 1, t);
        chk_eq("ns_rsp_vld", 64'(ns_rsp_vld), 64'd1);
        chk_eq("ns_rsp_err", 64'(ns_rsp_err), 64'd1);
        chk_eq("ns_rsp_rdata", 64'(ns_rsp_rdata), 64'd0);
        chk_eq("ns_req_rdy", 64'(ns_req_rdy), 64'd0);
        wait_done();
        chk_eq("ns_no_access", 64'(ns_act_cnt - nsb), 64'd0);
        chk_eq("split_acc_count", 64'(acc_q.size() - base), 64'd2);

        // Read data not valid
        vld_ok = 1'b0;
        issue(1'b0, 3'b010, 32'h01000010, 32'h0, 2, 32'h0, 1'b1, 1, t);
        wait_done();
        vld_ok = 1'b1;
        issue(1'b0, 3'b010, 32'h01000010, 32'h0, 2, 32'h80112233, 1'b0, 1, t);
        wait_done();

        // Split access wrapping from the top of the address space
        preload(4'd15, 32'hAB000000);
        preload(4'd0, 32'h000000CD);
        base = acc_q.size();
        issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 3, 32'hFFFFCDAB, 1'b0, 1, t);
        wait_done();
        chk_acc("wrap_acc1", base, 1, t, 2, 32'h00000000, 4'h0, 32'h0, 1'b1, 1'b0);

        // Reset during the second half of a split store
        preload(4'd0, 32'h0);
        preload(4'd1, 32'h0);
        issue(1'b1, 3'b010, 32'h01000002, 32'hA1B2C3D4, 0, 32'h0, 1'b0, 0, t);
        chk_eq("rstmid_acc0_we", 64'(mem_we), 64'd1);
        @(negedge clk);
        chk_eq("rstmid_acc1_addr", 64'(mem_addr), 64'h01000004);
        rst = 1'b1;
        #1;
        chk_eq("rstmid_we_gated", 64'(mem_we), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_eq("rstmid_req_rdy", 64'(req_rdy), 64'd1);
        chk_eq("rstmid_rsp_vld", 64'(rsp_vld), 64'd0);
        repeat (4) @(negedge clk);
        #1;
        chk_eq("rstmid_mem_lo", 64'(mem_arr[0]), 64'hC3D40000);
        chk_eq("rstmid_mem_hi", 64'(mem_arr[1]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
